soc_system_led_pattern_player: RTL and testbench
================================================

// Module: soc_system_led_pattern_player
// PURPOSE
// - Avalon-MM read master on port s2 of the 64 x 128-bit on-chip pattern RAM; HPS fills the RAM through port s1.
// - Fetches words START..END and plays each word as 16 LED frames, byte 0 (readdata[7:0]) first.
// - Holds each frame for DWELL clocks. Runs once or loops.
// - Controlled by a 4-register CSR slave on the lightweight HPS bridge. Drives the board LEDs.
// PARAMETERS
// - ADDR_W        6           RAM word address width (64 words)
// - DATA_W        128         RAM word width; must be a multiple of LED_W
// - LED_W         8           LED frame width; frames per word = DATA_W/LED_W (16)
// - DWELL_W       32          width of the dwell counter and DWELL register
// - DEFAULT_DWELL 50_000_000  DWELL reset value (1 s at 50 MHz)
// PORTS
// - clk             in   1       system clock; also clocks the RAM
// - reset_n         in   1       asynchronous active-low reset
// - csr_address     in   2       CSR word offset
// - csr_read        in   1       CSR read strobe; fixed read latency 1, no waitrequest
// - csr_write       in   1       CSR write strobe
// - csr_writedata   in   32      CSR write data
// - csr_readdata    out  32      CSR read data, registered
// - mem_address     out  ADDR_W  RAM s2 address
// - mem_chipselect  out  1       RAM s2 chipselect
// - mem_write       out  1       tied 0
// - mem_byteenable  out  16      tied all ones
// - mem_writedata   out  DATA_W  tied 0
// - mem_clken       out  1       tied 1
// - mem_readdata    in   DATA_W  RAM s2 read data; valid one cycle after address/chipselect
// - leds            out  LED_W   current frame
// BEHAVIOUR
// - Reset values: all outputs 0, except mem_clken=1 and mem_byteenable=all ones.
//   Reset values: CTRL=0, START=0, END=0, DWELL=DEFAULT_DWELL, done=0, FSM=IDLE.
// - CSR map (offset: write / read):
//   - 0: CTRL [0]=run [1]=loop / STATUS [0]=busy [1]=done [2]=loop [13:8]=cur_addr.
//     A write of run=1 clears done.
//   - 1: START [ADDR_W-1:0]
//   - 2: END [ADDR_W-1:0]
//   - 3: DWELL [DWELL_W-1:0]
//   - Unused bits read 0.
// - FSM states: IDLE, FETCH, WAIT, PLAY.
//   - IDLE -> FETCH when run=1; cur_addr <= START on that transition.
//   - FETCH: mem_chipselect=1 and mem_address=cur_addr for exactly one cycle, then WAIT.
//   - WAIT: word_reg <= mem_readdata; leds <= mem_readdata[LED_W-1:0]; frame=0; dwell_cnt=0. Next state PLAY.
//   - PLAY: dwell_cnt counts up to eff_dwell-1, where eff_dwell = max(DWELL,1). On expiry:
//     - frame != 15: frame++ and leds <= next byte.
//     - frame == 15, cur_addr != END: cur_addr++ (mod 64) -> FETCH.
//     - frame == 15, cur_addr == END, loop=1: cur_addr <= START -> FETCH.
//     - frame == 15, cur_addr == END, loop=0: run <= 0, done <= 1 -> IDLE.
// - Latency: byte 0 appears on leds at the 3rd rising edge after the edge that accepts the run=1 write.
//   Word-boundary gap: the last frame is held 2 extra clocks (FETCH + WAIT).
// - busy=1 in every state except IDLE. In IDLE, leds hold the last frame.
// - Boundary cases:
//   - START > END: play START..63, wrap to 0, continue to END (the address counter is modulo 64).
//   - START == END: single-word pattern.
//   - DWELL=0: treated as 1, i.e. one frame per clock.
//   - run=0 write mid-play: FSM goes to IDLE on the next edge; an outstanding fetch is discarded; done stays 0; leds hold.
//   - run=1 write while busy: no effect other than clearing done.
//   - START/END/loop writes while busy: sampled at the next word decision.
//   - DWELL write while busy: applies from the next dwell comparison.
//   - Simultaneous CSR write and internal done/run update: the internal update wins for run, the CSR write wins for loop.
//   - reset_n assertion mid-operation: all state returns to reset values immediately (asynchronous).
// STRUCTURE
// - Package led_player_pkg: state enum; CSR offsets (CSR_CTRL=0, CSR_START=1, CSR_END=2, CSR_DWELL=3); STATUS bit positions; FRAMES = DATA_W/LED_W.
// - One sub-module: led_player_frame_timer. Contains the dwell counter and the expiry pulse, with eff_dwell clamping.
// - Remaining logic (FSM, CSR, word/frame registers) stays in the top level.
// TESTING
// - Behavioural 64x128 RAM model with 1-cycle read latency. Word 0 = 0x0F0E..0100, DWELL=2, START=END=0, loop=0, run=1:
//   - leds shows 0x00..0x0F, 2 clocks each, first frame at edge 3; then done=1, busy=0, leds=0x0F.
// - START=62, END=1, loop=0, DWELL=1: exactly 4 fetches, at addresses 62, 63, 0, 1; done asserts after 64 frames plus gaps.
// - START=3, END=4, loop=1, DWELL=0: after word 4, frame 15, the next fetch address is 3; leds change every clock inside a word; busy stays 1.
// - Write run=0 during a WAIT cycle: no further fetches, FSM=IDLE on the next edge, leds unchanged, done=0. Then write run=1: a fetch from START follows.
// - Assert reset_n low during PLAY: leds=0, mem_chipselect=0, DWELL reads back 50_000_000 and STATUS reads 0 after release.
// - CSR readback: write 0x3F to START and 0xFFFFFFFF to CTRL. START reads 0x3F; CTRL/STATUS reads busy=1 and loop=1 with bits [31:14] all 0.

Source files
------------

// File: rtl/led_player_pkg.sv
// Shared types and constants for the LED pattern player: FSM states,
// CSR register offsets and STATUS bit positions.
package led_player_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        PLAY  = 2'd3
    } state_e;

    localparam logic [1:0] CSR_CTRL  = 2'd0;
    localparam logic [1:0] CSR_START = 2'd1;
    localparam logic [1:0] CSR_END   = 2'd2;
    localparam logic [1:0] CSR_DWELL = 2'd3;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_LOOP    = 2;
    localparam int STATUS_CUR_LSB = 8;

    localparam int PKG_DATA_W = 128;
    localparam int PKG_LED_W  = 8;
    localparam int FRAMES     = PKG_DATA_W / PKG_LED_W;

    function automatic int frames_per_word(int data_w, int led_w);
        return data_w / led_w;
    endfunction

endpackage

// File: rtl/led_player_frame_timer.sv
// Dwell counter for one LED frame: raises expire_o on the last clock of the
// dwell period; a dwell of 0 behaves like 1 (one frame per clock).
module led_player_frame_timer #(
    parameter int DWELL_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;
    logic [DWELL_W-1:0] last_cnt;

    // >= rather than == so a DWELL shrunk mid-frame expires at once instead of wrapping
    assign last_cnt = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
    assign expire_o = run_i && (cnt_q >= last_cnt);

    always_comb begin
        cnt_d = cnt_q + DWELL_W'(1);
        if (!run_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/soc_system_led_pattern_player.sv
// Plays 128-bit pattern RAM words as 16 LED frames each, fetching words
// START..END over a read-only Avalon-MM master and controlled by a 4-register CSR.
module soc_system_led_pattern_player
    import led_player_pkg::*;
#(
    parameter int ADDR_W        = 6,
    parameter int DATA_W        = 128,
    parameter int LED_W         = 8,
    parameter int DWELL_W       = 32,
    parameter int DEFAULT_DWELL = 50_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          csr_address,
    input  logic                csr_read,
    input  logic                csr_write,
    input  logic [31:0]         csr_writedata,
    output logic [31:0]         csr_readdata,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [LED_W-1:0]    leds
);

    localparam int NFRAMES = frames_per_word(DATA_W, LED_W);
    localparam int FRAME_W = $clog2(NFRAMES);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NFRAMES - 1);

    state_e              state_q;
    logic                run_q;
    logic                loop_q;
    logic                done_q;
    logic [ADDR_W-1:0]   start_q;
    logic [ADDR_W-1:0]   end_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic [ADDR_W-1:0]   cur_addr_q;
    logic [DATA_W-1:0]   word_q;
    logic [FRAME_W-1:0]  frame_q;
    logic [LED_W-1:0]    leds_q;
    logic [ADDR_W-1:0]   mem_address_q;
    logic                mem_cs_q;
    logic [31:0]         csr_readdata_q;
    logic [31:0]         csr_readdata_d;

    logic                expire;
    logic                stop_req;
    logic                last_word;
    logic                play_done;
    logic [ADDR_W-1:0]   next_addr;
    logic [FRAME_W-1:0]  frame_nxt;

    led_player_frame_timer #(
        .DWELL_W (DWELL_W)
    ) u_frame_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .run_i    (state_q == PLAY),
        .dwell_i  (dwell_q),
        .expire_o (expire)
    );

    assign stop_req  = csr_write && (csr_address == CSR_CTRL) && !csr_writedata[0];
    assign last_word = (cur_addr_q == end_q);
    assign next_addr = last_word ? start_q : cur_addr_q + ADDR_W'(1);
    assign frame_nxt = frame_q + FRAME_W'(1);
    assign play_done = (state_q == PLAY) && expire && (frame_q == FRAME_LAST)
                       && last_word && !loop_q;

    always_comb begin
        csr_readdata_d = '0;
        case (csr_address)
            CSR_CTRL: begin
                csr_readdata_d[STATUS_BUSY] = (state_q != IDLE);
                csr_readdata_d[STATUS_DONE] = done_q;
                csr_readdata_d[STATUS_LOOP] = loop_q;
                csr_readdata_d[STATUS_CUR_LSB +: ADDR_W] = cur_addr_q;
            end
            CSR_START: csr_readdata_d[ADDR_W-1:0]  = start_q;
            CSR_END:   csr_readdata_d[ADDR_W-1:0]  = end_q;
            default:   csr_readdata_d[DWELL_W-1:0] = dwell_q;
        endcase
    end

    // CSR writes come first so the FSM's own run/done updates override them on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            run_q          <= 1'b0;
            loop_q         <= 1'b0;
            done_q         <= 1'b0;
            start_q        <= '0;
            end_q          <= '0;
            dwell_q        <= DWELL_W'(DEFAULT_DWELL);
            cur_addr_q     <= '0;
            word_q         <= '0;
            frame_q        <= '0;
            leds_q         <= '0;
            mem_address_q  <= '0;
            mem_cs_q       <= 1'b0;
            csr_readdata_q <= '0;
        end else begin
            if (csr_write) begin
                case (csr_address)
                    CSR_CTRL: begin
                        run_q  <= csr_writedata[0];
                        loop_q <= csr_writedata[1];
                        if (csr_writedata[0]) begin
                            done_q <= 1'b0;
                        end
                    end
                    CSR_START: start_q <= csr_writedata[ADDR_W-1:0];
                    CSR_END:   end_q   <= csr_writedata[ADDR_W-1:0];
                    default:   dwell_q <= csr_writedata[DWELL_W-1:0];
                endcase
            end
            if (csr_read) begin
                csr_readdata_q <= csr_readdata_d;
            end

            mem_cs_q <= 1'b0;
            if (state_q != IDLE && stop_req && !play_done) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (run_q) begin
                            state_q       <= FETCH;
                            cur_addr_q    <= start_q;
                            mem_address_q <= start_q;
                            mem_cs_q      <= 1'b1;
                        end
                    end
                    FETCH: state_q <= WAIT;
                    WAIT: begin
                        word_q  <= mem_readdata;
                        leds_q  <= mem_readdata[LED_W-1:0];
                        frame_q <= '0;
                        state_q <= PLAY;
                    end
                    default: begin
                        if (expire) begin
                            if (frame_q != FRAME_LAST) begin
                                frame_q <= frame_nxt;
                                leds_q  <= word_q[frame_nxt*LED_W +: LED_W];
                            end else if (!last_word || loop_q) begin
                                cur_addr_q    <= next_addr;
                                mem_address_q <= next_addr;
                                mem_cs_q      <= 1'b1;
                                state_q       <= FETCH;
                            end else begin
                                run_q   <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign csr_readdata   = csr_readdata_q;
    assign mem_address    = mem_address_q;
    assign mem_chipselect = mem_cs_q;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_writedata  = '0;
    assign mem_clken      = 1'b1;
    assign leds           = leds_q;

endmodule

// File: tb/tb_soc_system_led_pattern_player.sv
// Bench for the LED pattern player: a RAM with one-cycle read latency and a
// timeline model that predicts leds and every fetch from the playback rules.
module tb_soc_system_led_pattern_player;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   csr_address;
    logic         csr_read;
    logic         csr_write;
    logic [31:0]  csr_writedata;
    logic [31:0]  csr_readdata;
    logic [5:0]   mem_address;
    logic         mem_chipselect;
    logic         mem_write;
    logic [15:0]  mem_byteenable;
    logic [127:0] mem_writedata;
    logic         mem_clken;
    logic [127:0] mem_readdata;
    logic [7:0]   leds;

    logic [127:0] ram [64];
    int           tests = 0;
    int           failures = 0;
    longint       cyc = 0;
    int           fetchLog [$];

    int           mStart;
    int           mEnd;
    int           mN;
    bit           mLoop;
    longint       mDwell;
    longint       acc = 0;
    bit           armed = 1'b0;
    logic [7:0]   prevLeds = 8'h00;
    logic [7:0]   expLeds = 8'h00;

    soc_system_led_pattern_player dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_address    (csr_address),
        .csr_read       (csr_read),
        .csr_write      (csr_write),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .leds           (leds)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= ram[mem_address];
    end

    always @(negedge clk) begin
        if (reset_n && mem_chipselect) fetchLog.push_back(int'(mem_address));
    end

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic longint period();
        return 16 * ((mDwell == 0) ? 1 : mDwell) + 2;
    endfunction

    // Word k's frame f shows from edge 3 + k*P + f*D; the last frame also covers the 2-clock refetch gap
    function automatic logic [7:0] modelLeds(longint t);
        longint d, p, k, o;
        int f, a;
        if (t < 3) return prevLeds;
        d = (mDwell == 0) ? 1 : mDwell;
        p = period();
        k = (t - 3) / p;
        o = (t - 3) % p;
        if (!mLoop && k >= mN) begin
            k = mN - 1;
            o = p - 1;
        end
        f = (o < 16 * d) ? int'(o / d) : 15;
        a = int'((mStart + k % mN) % 64);
        return ram[a][f*8 +: 8];
    endfunction

    function automatic bit modelFetch(longint t, output int addr);
        longint p, k;
        addr = 0;
        p = period();
        if (t < 1 || ((t - 1) % p) != 0) return 1'b0;
        k = (t - 1) / p;
        if (!mLoop && k >= mN) return 1'b0;
        addr = int'((mStart + k % mN) % 64);
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        longint t;
        logic [7:0] e;
        int a;
        bit fe;
        if (armed && reset_n) begin
            t = cyc - acc;
            e = modelLeds(t);
            checkOutput("leds", {24'd0, leds}, {24'd0, e});
            expLeds = e;
            fe = modelFetch(t, a);
            checkOutput("chipselect", {31'd0, mem_chipselect}, {31'd0, fe});
            if (fe) checkOutput("mem_address", {26'd0, mem_address}, a);
        end
    end

    task automatic csrWrite(logic [1:0] addr, logic [31:0] data);
        csr_address   = addr;
        csr_writedata = data;
        csr_write     = 1'b1;
        @(posedge clk);
        #1 csr_write = 1'b0;
    endtask

    task automatic csrRead(logic [1:0] addr, output logic [31:0] data);
        csr_address = addr;
        csr_read    = 1'b1;
        @(posedge clk);
        #1 csr_read = 1'b0;
        data = csr_readdata;
    endtask

    task automatic waitT(longint t);
        while (cyc - acc < t) @(negedge clk);
    endtask

    task automatic applyStimulus(int s, int e, longint d, bit lp, logic [31:0] ctrl);
        armed  = 1'b0;
        mStart = s;
        mEnd   = e;
        mDwell = d;
        mLoop  = lp;
        mN     = ((e - s + 64) % 64) + 1;
        csrWrite(2'd1, ($urandom & 32'hFFFF_FFC0) | s);
        csrWrite(2'd2, e);
        csrWrite(2'd3, d[31:0]);
        prevLeds = expLeds;
        csrWrite(2'd0, ctrl);
        acc   = cyc;
        armed = 1'b1;
    endtask

    task automatic stopPlay();
        armed   = 1'b0;
        expLeds = modelLeds(cyc - acc);
        csrWrite(2'd0, 32'd0);
    endtask

    task automatic finishOnce(string name);
        logic [31:0] r;
        waitT(3 + mN * period());
        csrRead(2'd0, r);
        checkOutput({name, " status after done"}, r, 32'h2 | (mEnd << 8));
        armed = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        int base;

        for (int a = 0; a < 64; a++)
            for (int w = 0; w < 4; w++) ram[a][w*32 +: 32] = $urandom;
        for (int f = 0; f < 16; f++) ram[0][f*8 +: 8] = 8'(f);

        reset_n = 1'b0;
        csr_address = 2'd0;
        csr_read = 1'b0;
        csr_write = 1'b0;
        csr_writedata = 32'd0;
        mem_readdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset leds", {24'd0, leds}, 32'd0);
        checkOutput("reset chipselect", {31'd0, mem_chipselect}, 32'd0);
        checkOutput("reset clken", {31'd0, mem_clken}, 32'd1);
        checkOutput("reset byteenable", {16'd0, mem_byteenable}, 32'hFFFF);
        checkOutput("reset readdata", csr_readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        csrRead(2'd3, r);
        checkOutput("reset dwell", r, 32'd50_000_000);

        // Single word 0x0F0E..0100, two clocks per frame
        applyStimulus(0, 0, 2, 1'b0, 32'h1);
        waitT(3); checkOutput("s1 frame0", {24'd0, leds}, 32'h00);
        waitT(5); checkOutput("s1 frame1", {24'd0, leds}, 32'h01);
        waitT(6); checkOutput("s1 frame1 held", {24'd0, leds}, 32'h01);
        waitT(33); checkOutput("s1 frame15", {24'd0, leds}, 32'h0F);
        finishOnce("s1");
        checkOutput("s1 leds hold", {24'd0, leds}, 32'h0F);

        // Wrap from 62 through 0 to 1
        base = fetchLog.size();
        applyStimulus(62, 1, 1, 1'b0, 32'h1);
        finishOnce("s2");
        checkOutput("s2 fetch count", fetchLog.size() - base, 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("s2 fetch addr", fetchLog[base + i], (62 + i) % 64);

        // Looping two words with DWELL=0
        base = fetchLog.size();
        applyStimulus(3, 4, 0, 1'b1, 32'h3);
        waitT(80);
        checkOutput("s3 second fetch", fetchLog[base + 1], 32'd4);
        checkOutput("s3 loop refetch", fetchLog[base + 2], 32'd3);
        csrRead(2'd0, r);
        checkOutput("s3 busy loop", r & 32'h7, 32'h5);
        stopPlay();
        repeat (3) @(negedge clk);
        checkOutput("s3 leds after stop", {24'd0, leds}, {24'd0, expLeds});

        // Stop during the WAIT cycle of the first fetch, then restart
        applyStimulus(9, 10, 1, 1'b1, 32'h3);
        waitT(2);
        armed = 1'b0;
        base = fetchLog.size();
        csrWrite(2'd0, 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("s4 no fetch after stop", fetchLog.size() - base, 32'd0);
        checkOutput("s4 leds unchanged", {24'd0, leds}, {24'd0, prevLeds});
        csrRead(2'd0, r);
        checkOutput("s4 status idle", r, 32'd9 << 8);
        base = fetchLog.size();
        applyStimulus(9, 10, 1, 1'b0, 32'h1);
        finishOnce("s4");
        checkOutput("s4 restart fetch", fetchLog[base], 32'd9);

        for (int i = 0; i < 6; i++) begin
            int s;
            s = int'($urandom_range(0, 63));
            applyStimulus(s, (s + int'($urandom_range(0, 3))) % 64,
                          longint'($urandom_range(0, 3)), 1'b0, 32'h1);
            csrRead(2'd1, r);
            checkOutput("rand start readback", r, s);
            finishOnce("rand");
        end

        // Asynchronous reset in the middle of playback
        applyStimulus(5, 6, 3, 1'b0, 32'h1);
        waitT(10);
        armed = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput("s5 leds in reset", {24'd0, leds}, 32'd0);
        checkOutput("s5 chipselect in reset", {31'd0, mem_chipselect}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        expLeds = 8'h00;
        @(negedge clk);
        csrRead(2'd3, r);
        checkOutput("s5 dwell after reset", r, 32'd50_000_000);
        csrRead(2'd0, r);
        checkOutput("s5 status after reset", r, 32'd0);

        // Readback with every CTRL bit set
        csrWrite(2'd1, 32'h3F);
        mStart = 63; mEnd = 0; mN = 2; mLoop = 1'b1; mDwell = 50_000_000;
        prevLeds = expLeds;
        csrWrite(2'd0, 32'hFFFF_FFFF);
        acc = cyc;
        armed = 1'b1;
        waitT(4);
        csrRead(2'd1, r);
        checkOutput("s6 start readback", r, 32'h3F);
        csrRead(2'd0, r);
        checkOutput("s6 status busy loop", r & 32'hFFFF_C007, 32'h5);
        stopPlay();
        repeat (3) @(negedge clk);
        checkOutput("s6 leds after stop", {24'd0, leds}, {24'd0, expLeds});
        csrRead(2'd0, r);
        checkOutput("s6 status after stop", r, 32'h3F00);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
